// File: rtl/key_lut_mux_if.sv
// key_lut_mux_if: write, lookup and result signals of the key lookup table
interface key_lut_mux_if #(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 8,
  parameter int CNT_LEN  = 8
);
  localparam int IDX_LEN = $clog2(NR_KEY);
  logic                wr_en;
  logic [IDX_LEN-1:0]  wr_idx;
  logic [KEY_LEN-1:0]  wr_key;
  logic [DATA_LEN-1:0] wr_data;
  logic                clr;
  logic [DATA_LEN-1:0] def_data;
  logic                in_valid;
  logic [KEY_LEN-1:0]  in_key;
  logic                out_valid;
  logic [DATA_LEN-1:0] out_data;
  logic                out_hit;
  logic [IDX_LEN-1:0]  out_idx;
  logic [CNT_LEN-1:0]  hit_cnt;
  modport master (
    output wr_en, wr_idx, wr_key, wr_data, clr, def_data, in_valid, in_key,
    input  out_valid, out_data, out_hit, out_idx, hit_cnt
  );
  modport slave (
    input  wr_en, wr_idx, wr_key, wr_data, clr, def_data, in_valid, in_key,
    output out_valid, out_data, out_hit, out_idx, hit_cnt
  );
endinterface

// File: rtl/key_lut_mux.sv
// key_lut_mux: writable key table with registered lookup and saturating hit counter
module key_lut_mux #(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 8,
  parameter int CNT_LEN  = 8
) (
  input logic clk,
  input logic rst,
  key_lut_mux_if.slave bus
);
  localparam int IDX_LEN = $clog2(NR_KEY);
  logic [NR_KEY-1:0]   v_q;
  logic [KEY_LEN-1:0]  key_q [NR_KEY];
  logic [DATA_LEN-1:0] tbl_q [NR_KEY];
  logic                valid_q;
  logic [DATA_LEN-1:0] data_q;
  logic                hit_q;
  logic [IDX_LEN-1:0]  idx_q;
  logic [CNT_LEN-1:0]  cnt_q;
  logic                hit_d;
  logic [IDX_LEN-1:0]  idx_d;
  logic                wr_ok;
  assign wr_ok = bus.wr_en && (int'(bus.wr_idx) < NR_KEY);
  // priority match over the pre-write table; scanning downward lets the lowest index win
  always_comb begin
    hit_d = 1'b0;
    idx_d = '0;
    for (int i = NR_KEY - 1; i >= 0; i--)
      if (v_q[i] && key_q[i] == bus.in_key) begin
        hit_d = 1'b1;
        idx_d = IDX_LEN'(i);
      end
  end
  // valid bits: clr drops all, a same-cycle write re-validates its own entry
  always_ff @(posedge clk) begin
    if (rst) v_q <= '0;
    else begin
      if (bus.clr) v_q <= '0;
      if (wr_ok) v_q[bus.wr_idx] <= 1'b1;
    end
  end
  // key/data storage, intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      key_q[bus.wr_idx] <= bus.wr_key;
      tbl_q[bus.wr_idx] <= bus.wr_data;
    end
  end
  // registered lookup result and saturating hit counter; result fields hold when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        data_q <= hit_d ? tbl_q[idx_d] : bus.def_data;
        hit_q  <= hit_d;
        idx_q  <= idx_d;
        if (hit_d && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      end
    end
  end
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_hit   = hit_q;
  assign bus.out_idx   = idx_q;
  assign bus.hit_cnt   = cnt_q;
endmodule

// File: tb/tb_key_lut_mux.sv
// tb_key_lut_mux: directed checks of lookup, priority, clr/write ordering and counter saturation
module tb_key_lut_mux;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  key_lut_mux_if a ();
  key_lut_mux_if #(.CNT_LEN(2)) b ();
  assign b.wr_en    = a.wr_en;
  assign b.wr_idx   = a.wr_idx;
  assign b.wr_key   = a.wr_key;
  assign b.wr_data  = a.wr_data;
  assign b.clr      = a.clr;
  assign b.def_data = a.def_data;
  assign b.in_valid = a.in_valid;
  assign b.in_key   = a.in_key;
  key_lut_mux u8 (.clk(clk), .rst(rst), .bus(a));
  key_lut_mux #(.CNT_LEN(2)) u2 (.clk(clk), .rst(rst), .bus(b));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input int idx, input int key, input int data);
    a.wr_en = 1'b1;
    a.wr_idx = 2'(idx);
    a.wr_key = 2'(key);
    a.wr_data = 8'(data);
    tick();
    a.wr_en = 1'b0;
  endtask
  task automatic res(input string tag, input logic v, input logic h, input int d, input int i);
    chk({tag, "_valid"}, 32'(a.out_valid), 32'(v));
    chk({tag, "_hit"}, 32'(a.out_hit), 32'(h));
    chk({tag, "_data"}, 32'(a.out_data), d);
    chk({tag, "_idx"}, 32'(a.out_idx), i);
  endtask
  initial begin
    a.wr_en = 0; a.wr_idx = 0; a.wr_key = 0; a.wr_data = 0;
    a.clr = 0; a.def_data = 0; a.in_valid = 0; a.in_key = 0;
    tick(); tick();
    res("rst", 0, 0, 0, 0);
    chk("rst_cnt", 32'(a.hit_cnt), 0);
    rst = 0;
    a.in_valid = 1; a.in_key = 2; a.def_data = 8'hAA;
    tick();
    a.in_valid = 0;
    res("miss_empty", 1, 0, 'hAA, 0);
    chk("miss_empty_cnt", 32'(a.hit_cnt), 0);
    for (int i = 0; i < 4; i++) wr(i, i, 'h10 * (i + 1));
    chk("idle_valid", 32'(a.out_valid), 0);
    chk("idle_hold", 32'(a.out_data), 'hAA);
    a.in_valid = 1; a.in_key = 3;
    tick();
    res("b2b_k3", 1, 1, 'h40, 3);
    a.in_key = 1;
    tick();
    res("b2b_k1", 1, 1, 'h20, 1);
    a.in_key = 0;
    tick();
    a.in_valid = 0;
    res("b2b_k0", 1, 1, 'h10, 0);
    chk("b2b_cnt", 32'(a.hit_cnt), 3);
    wr(1, 2, 'h55);
    wr(3, 2, 'h66);
    a.in_valid = 1; a.in_key = 2;
    tick();
    a.in_valid = 0;
    res("dup", 1, 1, 'h55, 1);
    chk("dup_cnt", 32'(a.hit_cnt), 4);
    a.clr = 1;
    tick();
    a.clr = 0;
    a.wr_en = 1; a.wr_idx = 0; a.wr_key = 1; a.wr_data = 8'h77;
    a.in_valid = 1; a.in_key = 1; a.def_data = 8'hEE;
    tick();
    a.wr_en = 0;
    res("rbw_miss", 1, 0, 'hEE, 0);
    tick();
    a.in_valid = 0;
    res("rbw_hit", 1, 1, 'h77, 0);
    chk("rbw_cnt", 32'(a.hit_cnt), 5);
    wr(1, 3, 'h33);
    wr(3, 0, 'h44);
    a.clr = 1;
    wr(2, 0, 'h99);
    a.clr = 0;
    a.in_valid = 1; a.in_key = 0; a.def_data = 8'hBB;
    tick();
    res("clrwr_k0", 1, 1, 'h99, 2);
    a.in_key = 3;
    tick();
    a.in_valid = 0;
    res("clrwr_k3", 1, 0, 'hBB, 0);
    chk("clrwr_cnt", 32'(a.hit_cnt), 6);
    rst = 1;
    tick();
    rst = 0;
    chk("rst2_cnt8", 32'(a.hit_cnt), 0);
    chk("rst2_cnt2", 32'(b.hit_cnt), 0);
    wr(0, 2, 'h12);
    a.in_valid = 1; a.in_key = 2;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("sat_cnt2_%0d", i), 32'(b.hit_cnt), (i < 3) ? i : 3);
      chk($sformatf("cnt8_%0d", i), 32'(a.hit_cnt), i);
    end
    chk("sat_data", 32'(b.out_data), 'h12);
    rst = 1;
    tick();
    rst = 0;
    a.in_valid = 0;
    chk("midrst_valid", 32'(b.out_valid), 0);
    chk("midrst_cnt2", 32'(b.hit_cnt), 0);
    chk("midrst_data", 32'(a.out_data), 0);
    tick();
    chk("midrst_drop", 32'(a.out_valid), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
